// File: rtl/tt_capture4_if.sv
// Bus bundle for tt_capture4: sweep control/status plus the minterm drive
// (x0..x3) and the function-under-test response (y0).
// master: the host/harness side that requests sweeps and supplies y0.
// slave : the capture block itself.
interface tt_capture4_if;
  logic        start;
  logic        x0;
  logic        x1;
  logic        x2;
  logic        x3;
  logic        y0;
  logic        busy;
  logic        done;
  logic [15:0] tt;
  logic        match;

  modport master (
    output start, y0,
    input  x0, x1, x2, x3, busy, done, tt, match
  );

  modport slave (
    input  start, y0,
    output x0, x1, x2, x3, busy, done, tt, match
  );
endinterface

// File: rtl/tt_capture4.sv
// Truth-table capture stage for 4-input, single-output netlists.
// Walks minterms 0..15 out on x0..x3 (m = {x3,x2,x1,x0}), samples y0 LAT
// cycles later through an index/valid pipeline, and assembles tt[m] = y0.
// Optional feature: define TT_COMPARE_EN to register match = (tt == EXPECTED)
// at the DONE transition; without it match is tied to 0.
module tt_capture4 #(
  parameter int          LAT      = 0,        // y0 latency in cycles, 0..3
  parameter logic [15:0] EXPECTED = 16'hF94C  // reference truth table
) (
  input  logic         clk,
  input  logic         rst,
  tt_capture4_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        busy_c;
  logic        done_c;

  // Five bits so that "all 16 issued" is cnt[4], never a wrap back to 0.
  logic [4:0]  cnt;

  // Stage 0 is the issue register (it drives x); stage LAT is the one whose
  // y0 response is valid this cycle.
  logic        pipe_vld [0:LAT];
  logic [3:0]  pipe_idx [0:LAT];

  logic [15:0] tt_q;
  logic [15:0] tt_nxt;
  logic        launch;
  logic        capture;
  logic        last_capture;

  assign launch       = (state == IDLE) && bus.start;
  assign capture      = pipe_vld[LAT];
  assign last_capture = capture && (pipe_idx[LAT] == 4'hF);

  // State register.
  // NOTE: clocked blocks use non-blocking (<=) so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs; start is only honoured in IDLE.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) state_nxt = SWEEP;
      SWEEP: begin
        busy_c = 1'b1;
        if (last_capture) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;

  // Issue stage and latency pipeline: one minterm per cycle, index+valid shifted LAT deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 5'd0;
      // NOTE: index stages are reset too, not just valids, because stage 0 drives x.
      for (int i = 0; i <= LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_idx[i] <= 4'h0;
      end
    end else begin
      if (launch) begin
        pipe_vld[0] <= 1'b1;
        pipe_idx[0] <= 4'h0;
        cnt         <= 5'd1;
      end else if ((state == SWEEP) && !cnt[4]) begin
        pipe_vld[0] <= 1'b1;
        pipe_idx[0] <= cnt[3:0];
        cnt         <= cnt + 5'd1;
      end else begin
        pipe_vld[0] <= 1'b0;
        pipe_idx[0] <= 4'h0;
      end
      for (int i = 1; i <= LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  assign {bus.x3, bus.x2, bus.x1, bus.x0} = pipe_idx[0];

  // Truth table with this cycle's sample merged in (also feeds the comparator).
  always_comb begin
    tt_nxt = tt_q;
    if (capture) tt_nxt[pipe_idx[LAT]] = bus.y0;
  end

  // Truth-table register: cleared on launch, filled during SWEEP, held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 tt_q <= 16'h0000;
    else if (launch)         tt_q <= 16'h0000;
    else if (state == SWEEP) tt_q <= tt_nxt;
  end

  assign bus.tt = tt_q;

`ifdef TT_COMPARE_EN
  logic match_q;

  // Compare the final table at the edge that enters DONE, so match lines up with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  match_q <= 1'b0;
    else if (launch)                          match_q <= 1'b0;
    else if ((state == SWEEP) && last_capture) match_q <= (tt_nxt == EXPECTED);
  end

  assign bus.match = match_q;
`else
  // Folds to constant 0; EXPECTED stays referenced without any comparator.
  assign bus.match = |(EXPECTED & 16'h0000);
`endif

endmodule

// File: tb/tb_tt_capture4.sv
// Directed bench for tt_capture4: one instance with LAT=0 (combinational
// function model) and one with LAT=2 (model followed by two flops), sharing
// clock, reset and start. Expected match depends on TT_COMPARE_EN.
module tb_tt_capture4;

`ifdef TT_COMPARE_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  logic start;
  logic zero_mode;
  logic [15:0] fut_tbl;

  int vectors;
  int miscompares;

  tt_capture4_if b0 ();
  tt_capture4_if b2 ();

  tt_capture4 #(.LAT(0)) u_lat0 (.clk(clk), .rst(rst), .bus(b0));
  tt_capture4 #(.LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(b2));

  logic [3:0] m0;
  logic [3:0] m2;
  logic       y2_d1;
  logic       y2_d2;

  assign m0 = {b0.x3, b0.x2, b0.x1, b0.x0};
  assign m2 = {b2.x3, b2.x2, b2.x1, b2.x0};

  assign b0.start = start;
  assign b2.start = start;

  // Function under test 0xF94C (or constant 0 when zero_mode is set).
  assign b0.y0 = zero_mode ? 1'b0 : fut_tbl[m0];

  // Same function behind a 2-flop delay for the LAT=2 instance.
  always @(posedge clk) begin
    y2_d1 <= zero_mode ? 1'b0 : fut_tbl[m2];
    y2_d2 <= y2_d1;
  end
  assign b2.y0 = y2_d2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Call from mid-cycle with both instances idle; start is raised for E0.
  task automatic run_sweep(input string name, input bit repulse, input bit zero);
    logic [15:0] tt_exp;
    logic [15:0] x_exp;
    logic        m_exp;
    tt_exp    = zero ? 16'h0000 : fut_tbl;
    m_exp     = CMP_ON && !zero;
    zero_mode = zero;
    start     = 1'b1;
    @(posedge clk);  // E0
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);  // cycle after E(c)
      start = repulse && (c == 4 || c == 9);
      x_exp = (c < 16) ? 16'(c) : 16'h0000;
      check($sformatf("%s x lat0 c%0d", name, c), 16'(m0), x_exp);
      check($sformatf("%s x lat2 c%0d", name, c), 16'(m2), x_exp);
      check($sformatf("%s busy lat0 c%0d", name, c), 16'(b0.busy), 16'(c < 16));
      check($sformatf("%s busy lat2 c%0d", name, c), 16'(b2.busy), 16'(c < 18));
      check($sformatf("%s done lat0 c%0d", name, c), 16'(b0.done), 16'(c == 16));
      check($sformatf("%s done lat2 c%0d", name, c), 16'(b2.done), 16'(c == 18));
      if (c == 0) begin
        check({name, " tt cleared lat0"}, b0.tt, 16'h0000);
        check({name, " tt cleared lat2"}, b2.tt, 16'h0000);
        check({name, " match cleared lat0"}, 16'(b0.match), 16'h0000);
        check({name, " match cleared lat2"}, 16'(b2.match), 16'h0000);
      end
      if (c == 8) begin
        check({name, " partial tt lat0"}, b0.tt, tt_exp & 16'h00FF);
        check({name, " partial tt lat2"}, b2.tt, tt_exp & 16'h003F);
      end
      if (c == 16) begin
        check({name, " final tt lat0"}, b0.tt, tt_exp);
        check({name, " match lat0"}, 16'(b0.match), 16'(m_exp));
        check({name, " partial tt lat2 c16"}, b2.tt, tt_exp & 16'h3FFF);
      end
      if (c == 18) begin
        check({name, " final tt lat2"}, b2.tt, tt_exp);
        check({name, " match lat2"}, 16'(b2.match), 16'(m_exp));
      end
      if (c == 19) begin
        check({name, " tt hold lat0"}, b0.tt, tt_exp);
        check({name, " tt hold lat2"}, b2.tt, tt_exp);
        check({name, " match hold lat0"}, 16'(b0.match), 16'(m_exp));
      end
    end
  endtask

  initial begin
    int dcount;
    vectors     = 0;
    miscompares = 0;
    fut_tbl     = 16'hF94C;
    zero_mode   = 1'b0;
    start       = 1'b0;
    rst         = 1'b1;

    // Reset state.
    #8;
    check("rst x lat0", 16'(m0), 16'h0000);
    check("rst busy lat0", 16'(b0.busy), 16'h0000);
    check("rst done lat0", 16'(b0.done), 16'h0000);
    check("rst tt lat0", b0.tt, 16'h0000);
    check("rst match lat0", 16'(b0.match), 16'h0000);
    check("rst busy lat2", 16'(b2.busy), 16'h0000);
    check("rst tt lat2", b2.tt, 16'h0000);

    // First start accepted on the first edge after reset release.
    #4;
    rst = 1'b0;
    run_sweep("base", 1'b0, 1'b0);
    run_sweep("repulse", 1'b1, 1'b0);
    run_sweep("zero", 1'b0, 1'b1);

    // Asynchronous reset mid-cycle after E8.
    zero_mode = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);  // E0
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);  // E1..E8
    #3;
    rst = 1'b1;
    #1;
    check("midrst busy lat0", 16'(b0.busy), 16'h0000);
    check("midrst busy lat2", 16'(b2.busy), 16'h0000);
    check("midrst tt lat0", b0.tt, 16'h0000);
    check("midrst tt lat2", b2.tt, 16'h0000);
    check("midrst x lat0", 16'(m0), 16'h0000);
    check("midrst x lat2", 16'(m2), 16'h0000);
    check("midrst done lat0", 16'(b0.done), 16'h0000);
    @(negedge clk);
    rst    = 1'b0;
    dcount = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      dcount += int'(b0.done) + int'(b2.done);
    end
    check("midrst no done pulse", 16'(dcount), 16'h0000);
    check("midrst idle lat2", 16'(b2.busy), 16'h0000);
    run_sweep("post_rst", 1'b0, 1'b0);

    // Start held high: relaunch on the first IDLE cycle after DONE.
    start = 1'b1;
    @(posedge clk);  // E0
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (c == 16) check("held done lat0 c16", 16'(b0.done), 16'h0001);
      if (c == 17) begin
        check("held busy lat0 c17", 16'(b0.busy), 16'h0000);
        check("held done lat0 c17", 16'(b0.done), 16'h0000);
      end
      if (c == 18) begin
        check("held busy lat0 c18", 16'(b0.busy), 16'h0001);
        check("held done lat0 c18", 16'(b0.done), 16'h0000);
        check("held x lat0 c18", 16'(m0), 16'h0000);
        check("held tt cleared lat0", b0.tt, 16'h0000);
      end
    end
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
